// File: rtl/ahb_matmul_engine_if.sv
// AHB-Lite bus bundle for ahb_matmul_engine.
//   slave  : HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA in,
//            HRDATA/HREADYOUT/HRESP out
//   master : the mirror image; HREADY is an input because the interconnect drives it.
interface ahb_matmul_engine_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT, HRESP, HREADY
  );
endinterface

// File: rtl/ahb_matmul_engine.sv
// AHB-Lite slave computing C = A * B for signed NxN matrices with a single
// sequential MAC (one product per cycle). A/B/C are word-mapped at 0x000,
// 0x400 and 0x800; CTRL (START, IRQ_EN) at 0xC00, STATUS (BUSY, DONE) at 0xC04.
// Array accesses during a computation are held off with HREADYOUT.
// Ports:
//   HCLK, HRESET : clock, asynchronous active-high reset
//   bus          : AHB-Lite slave modport (see ahb_matmul_engine_if)
//   IRQ          : registered level interrupt, DONE & IRQ_EN
//
// state   | meaning
// S_IDLE  | waiting for START; BUSY=0
// S_MAC   | accumulating A[i][k]*B[k][j], k = 0..N-1
// S_STORE | write acc into C[i][j], step j then i
module ahb_matmul_engine #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_matmul_engine_if.slave bus,
  output logic               IRQ
);
  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE} state_t;
  state_t r_state, w_state_nxt;

  logic                     r_dp_valid, r_dp_write;
  logic [11:0]              r_dp_addr;
  logic signed [DATA_W-1:0] r_mem_a [NN];
  logic signed [DATA_W-1:0] r_mem_b [NN];
  logic signed [ACC_W-1:0]  r_mem_c [NN];
  logic [KW-1:0]            r_i, r_j, r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_done, r_irq_en, r_irq;

  logic                       w_busy, w_stall, w_wr, w_idx_ok, w_start, w_w1c;
  logic                       w_last_k, w_last_elem;
  logic [1:0]                 w_region;
  logic [7:0]                 w_idx;
  logic [IW-1:0]              w_idx_m, w_a_idx, w_b_idx, w_c_idx;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [31:0]                w_rdata;
  logic                       w_unused;

  assign w_region = r_dp_addr[11:10];
  assign w_idx    = r_dp_addr[9:2];
  assign w_idx_ok = ({1'b0, w_idx} < 9'(NN));
  assign w_idx_m  = w_idx[IW-1:0];

  assign w_busy  = (r_state != S_IDLE);
  // Only array accesses conflict with the engine; CTRL/STATUS always complete.
  assign w_stall = r_dp_valid && (w_region != 2'b11) && w_busy;
  assign w_wr    = r_dp_valid && r_dp_write && !w_stall;
  assign w_start = w_wr && (r_dp_addr == 12'hC00) && bus.HWDATA[0];
  assign w_w1c   = w_wr && (r_dp_addr == 12'hC04) && bus.HWDATA[1];

  assign w_last_k    = (r_k == KW'(N - 1));
  assign w_last_elem = (r_i == KW'(N - 1)) && (r_j == KW'(N - 1));
  assign w_a_idx     = IW'(int'(r_i) * N + int'(r_k));
  assign w_b_idx     = IW'(int'(r_k) * N + int'(r_j));
  assign w_c_idx     = IW'(int'(r_i) * N + int'(r_j));
  assign w_prod      = (2*DATA_W)'(r_mem_a[w_a_idx]) * (2*DATA_W)'(r_mem_b[w_b_idx]);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else if (bus.HREADY) begin
      r_dp_valid <= bus.HSEL & bus.HTRANS[1];
      r_dp_write <= bus.HWRITE;
      r_dp_addr  <= bus.HADDR[11:0];
    end
  end

  // Matrix storage is deliberately left without reset.
  always_ff @(posedge HCLK) begin
    if (w_wr && w_idx_ok && (w_region == 2'b00)) r_mem_a[w_idx_m] <= bus.HWDATA[DATA_W-1:0];
    if (w_wr && w_idx_ok && (w_region == 2'b01)) r_mem_b[w_idx_m] <= bus.HWDATA[DATA_W-1:0];
    if (r_state == S_STORE) r_mem_c[w_c_idx] <= r_acc;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_MAC;
      S_MAC:   if (w_last_k) w_state_nxt = S_STORE;
      S_STORE: w_state_nxt = w_last_elem ? S_IDLE : S_MAC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_i   <= '0;
          r_j   <= '0;
          r_k   <= '0;
          r_acc <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_k   <= r_k + 1'b1;
        end
        S_STORE: begin
          r_acc <= '0;
          r_k   <= '0;
          if (r_j == KW'(N - 1)) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        default: r_k <= '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      // Completion beats a simultaneous clear so a finished result is never lost.
      if ((r_state == S_STORE) && w_last_elem) r_done <= 1'b1;
      else if (w_start || w_w1c)               r_done <= 1'b0;
      if (w_wr && (r_dp_addr == 12'hC00)) r_irq_en <= bus.HWDATA[1];
      r_irq <= r_done & r_irq_en;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (w_region)
        2'b00:   if (w_idx_ok) w_rdata = 32'(r_mem_a[w_idx_m]);
        2'b01:   if (w_idx_ok) w_rdata = 32'(r_mem_b[w_idx_m]);
        2'b10:   if (w_idx_ok) w_rdata = 32'(r_mem_c[w_idx_m]);
        default: begin
          if (r_dp_addr == 12'hC00)      w_rdata = {30'b0, r_irq_en, 1'b0};
          else if (r_dp_addr == 12'hC04) w_rdata = {30'b0, r_done, w_busy};
        end
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = !w_stall;
  assign bus.HRESP     = 1'b0;
  assign IRQ           = r_irq;

  assign w_unused = ^{bus.HSIZE, bus.HADDR[31:12], bus.HADDR[1:0], bus.HWDATA, r_dp_addr[1:0]};
endmodule

// File: tb/tb_ahb_matmul_engine.sv
module tb_ahb_matmul_engine;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int NN  = N * N;
  localparam int LAT = NN * (N + 1);
  localparam logic [11:0] A_BASE = 12'h000;
  localparam logic [11:0] B_BASE = 12'h400;
  localparam logic [11:0] C_BASE = 12'h800;
  localparam logic [11:0] CTRL   = 12'hC00;
  localparam logic [11:0] STATUS = 12'hC04;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  ahb_matmul_engine_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus),
    .IRQ   (irq)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          ma [NN];
  int          mb [NN];
  logic [31:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; returns at the negedge before the completing edge.
  task automatic bus_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits);
    int n;
    @(posedge clk); #1;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = {20'h0, addr};
    @(posedge clk); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = wdata;
    n = 0;
    @(negedge clk);
    while (!bus.HREADYOUT && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("hready_timeout", {31'b0, bus.HREADYOUT}, 32'd1);
    rdata = bus.HRDATA;
    waits = n;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] d;
    int w;
    bus_xfer(1'b1, addr, data, d, w);
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data, output int waits);
    bus_xfer(1'b0, addr, 32'h0, data, waits);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    rd(addr, d, w);
    chk(tag, d, exp);
  endtask

  task automatic load_mats();
    for (int i = 0; i < NN; i++) begin
      wr(A_BASE + 12'(4 * i), 32'(ma[i]));
      wr(B_BASE + 12'(4 * i), 32'(mb[i]));
    end
  endtask

  task automatic push_model();
    int s;
    logic signed [AW-1:0] t;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i*N + k] * mb[k*N + j];
        t = AW'(s);
        sb_q.push_back(32'(t));
      end
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (sb_q.size() == 0) return 32'hDEAD_BEEF;
    return sb_q.pop_front();
  endfunction

  task automatic check_c(input string tag, input int from);
    logic [31:0] d;
    int w;
    for (int i = from; i < NN; i++) begin
      rd(C_BASE + 12'(4 * i), d, w);
      chk($sformatf("%s c[%0d]", tag, i), d, pop_exp());
    end
  endtask

  // Read C[0] straight after START; returns the stall length.
  task automatic stall_read_c0(input string tag, input int exp_waits);
    logic [31:0] d;
    int w;
    rd(C_BASE, d, w);
    chk({tag, " stall"}, w, exp_waits);
    chk({tag, " c[0]"}, d, pop_exp());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    bus.HADDR = '0; bus.HWDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("rst hrdata", bus.HRDATA, 32'd0);
    chk("rst irq", {31'b0, irq}, 32'd0);
    chk("rst hresp", {31'b0, bus.HRESP}, 32'd0);
    rst = 1'b0;
    rd_chk("rst status", STATUS, 32'h0);
    rd_chk("rst ctrl", CTRL, 32'h0);

    // Identity times a signed ramp
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i / N == i % N) ? 1 : 0;
      mb[i] = i - 8;
    end
    load_mats();
    push_model();
    wr(CTRL, 32'h1);
    stall_read_c0("ident", LAT - 1);
    rd_chk("ident status", STATUS, 32'h2);
    check_c("ident", 1);
    rd_chk("b[3] sext", B_BASE + 12'd12, 32'hFFFF_FFFB);
    rd_chk("a[5]", A_BASE + 12'd20, 32'h1);

    // Accumulator wrap: 2 * (-128 * -128) = 0x8000 in 16 bits
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % N < 2) ? -128 : 0;
      mb[i] = -128;
    end
    load_mats();
    push_model();
    wr(CTRL, 32'h3);
    rd(CTRL, d, w);
    chk("busy ctrl data", d, 32'h2);
    chk("busy ctrl waits", w, 0);
    rd_chk("busy status", STATUS, 32'h1);
    stall_read_c0("wrap", LAT - 5);
    chk("irq lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq set", {31'b0, irq}, 32'd1);
    check_c("wrap", 1);
    wr(STATUS, 32'h2);
    @(negedge clk);
    chk("irq hold", {31'b0, irq}, 32'd1);
    @(negedge clk);
    chk("irq clr", {31'b0, irq}, 32'd0);
    rd_chk("w1c status", STATUS, 32'h0);

    // Random operands, second START mid-run must not restart
    for (int i = 0; i < NN; i++) begin
      ma[i] = int'($urandom_range(0, 255)) - 128;
      mb[i] = int'($urandom_range(0, 255)) - 128;
    end
    ma[0] = -128; mb[0] = 127;
    load_mats();
    push_model();
    wr(CTRL, 32'h1);
    repeat (10) @(posedge clk);
    wr(CTRL, 32'h1);
    stall_read_c0("restart", LAT - 13);
    check_c("rand", 1);

    // W1C landing on the final STORE edge: DONE must survive
    push_model();
    wr(CTRL, 32'h1);
    repeat (LAT - 2) @(posedge clk);
    wr(STATUS, 32'h2);
    rd_chk("set wins", STATUS, 32'h2);
    check_c("setwin", 0);

    // Reset in the middle of a run, with a stalled C read pending
    wr(CTRL, 32'h3);
    repeat (40) @(posedge clk);
    #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {20'h0, C_BASE};
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    chk("pre-rst stall", {31'b0, bus.HREADYOUT}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid-rst hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("mid-rst hrdata", bus.HRDATA, 32'd0);
    chk("mid-rst irq", {31'b0, irq}, 32'd0);
    chk("mid-rst hresp", {31'b0, bus.HRESP}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("post-rst status", STATUS, 32'h0);
    rd_chk("post-rst ctrl", CTRL, 32'h0);
    push_model();
    wr(CTRL, 32'h1);
    stall_read_c0("rerun", LAT - 1);
    check_c("rerun", 1);

    // Out-of-range and read-only addresses
    wr(A_BASE + 12'(4 * NN), 32'h55);
    rd_chk("a oob read", A_BASE + 12'(4 * NN), 32'h0);
    rd_chk("a[0] intact", A_BASE, 32'(ma[0]));
    wr(B_BASE + 12'(4 * NN), 32'h33);
    rd_chk("b[0] intact", B_BASE, 32'(mb[0]));
    wr(C_BASE, 32'h1234);
    push_model();
    rd_chk("c ro", C_BASE, pop_exp());
    sb_q.delete();
    wr(12'hC08, 32'hFFFF_FFFF);
    rd_chk("unmapped", 12'hC08, 32'h0);
    rd_chk("ctrl final", CTRL, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_matmul_engine.md
# ahb_matmul_engine

Parametrised AHB-Lite slave that multiplies two N×N signed matrices, the next generation of the team's fixed 8×8 `matrix_mult` peripheral. The bus master loads A and B and writes START. A sequential MAC engine fills C, which the master reads back over HRDATA. Status and an optional interrupt report completion; bus accesses that collide with an active computation are stalled with HREADYOUT.

## Interface
- N, 8: matrix dimension, 2..16.
- DATA_W, 8: element width of A/B, signed, 2..16.
- ACC_W, 32: accumulator/C width, signed, must be ≥ 2*DATA_W and ≤ 32.

- HCLK  in  1  clock
- HRESET  in  1  asynchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; only HADDR[11:0] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer
- HWRITE  in  1  1 = write
- HSIZE  in  3  ignored; all accesses treated as 32-bit words
- HREADY  in  1  bus ready from interconnect
- HWDATA  in  32  write data, data phase
- HRDATA  out  32  read data, data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  tied 0 (OKAY)
- IRQ  out  1  level interrupt, DONE & IRQ_EN

## Operation
- Address map, word index idx = HADDR[9:2], row-major (idx = row*N + col):
  - A at 0x000 + 4*idx.
  - B at 0x400 + 4*idx.
  - C at 0x800 + 4*idx (read-only).
  - CTRL at 0xC00: bit0 START (write-1, self-clearing, reads 0), bit1 IRQ_EN (R/W).
  - STATUS at 0xC04: bit0 BUSY (RO), bit1 DONE (write-1-to-clear).
- Accesses to idx ≥ N*N within any array, and to unmapped addresses: reads return 0, writes are ignored.
- Writes to C are ignored.
- A/B writes store HWDATA[DATA_W-1:0]. A/B reads return the value sign-extended to 32 bits. C reads return ACC_W sign-extended to 32 bits.
- Engine FSM:
  - IDLE: a START write moves to MAC with i=j=k=0 and acc=0. A START write while not IDLE is ignored.
  - MAC: acc += sext(A[i][k]) * sext(B[k][j]) mod 2^ACC_W, one product per cycle, k = 0..N-1. After k=N-1, go to STORE.
  - STORE: C[i][j] ← acc, acc ← 0, k ← 0. Advance j, then i. After i=j=N-1, go to IDLE and set DONE; otherwise go back to MAC.
- BUSY = (state ≠ IDLE).
- A START write also clears DONE.
- If DONE is set by the engine and cleared by a W1C in the same cycle, set wins.
- A, B and C arrays are not reset.
- Reset clears FSM→IDLE, counters, acc, DONE, IRQ_EN, IRQ, and the captured address phase.

## Timing
- Address phase is captured on the HCLK edge where HSEL & HREADY & HTRANS[1]. The data phase is the following cycle.
- Writes commit on the edge ending the data phase.
- HRDATA is combinational from the captured address during the data phase. Reads of CTRL/STATUS never stall.
- HREADYOUT:
  - 1 at reset and in all idle/no-transfer cycles.
  - 0 during a data phase that targets A, B or C while BUSY=1. It rises in the first cycle with BUSY=0; the transfer then completes, and a C read returns the final result.
- Compute latency: the START data phase ends at edge t, so BUSY=1 from t. STORE of the last element occurs at cycle t + N*N*(N+1) - 1. BUSY=0 and DONE=1 from edge t + N*N*(N+1). For N=8 that is 576 cycles; for N=2, 12 cycles.
- IRQ is registered: it asserts 1 cycle after DONE & IRQ_EN becomes true and drops 1 cycle after either clears.
- Reset mid-compute: all outputs return to reset values immediately (HRDATA=0, HREADYOUT=1, IRQ=0, HRESP=0). Partially written C is left as is.
- Back-to-back pipelined transfers: a new address phase is accepted in the same cycle as the previous data phase whenever HREADYOUT=1.

## Test plan
- Identity multiply, N=8, DATA_W=8: A=I, B[i]=i-32 (signed). Write START, poll STATUS until BUSY=0 → C[i] = i-32 for all 64 words; DONE=1 exactly 576 cycles after the START edge.
- Signed/overflow, N=2, DATA_W=8, ACC_W=16: all A=B=-128 → every C = 2*16384 = 32768 mod 2^16, read as 0xFFFF8000.
- Stall: after START, issue a read of C[0] at once → HREADYOUT=0 until BUSY falls; the read then returns the final C[0]. A CTRL read during BUSY completes with no wait states.
- IRQ and W1C: IRQ_EN=1, START → IRQ=1 one cycle after DONE. Write STATUS=0x2 → DONE=0, IRQ=0 next cycle. A W1C coinciding with the final STORE leaves DONE=1.
- Reset mid-compute: assert HRESET 100 cycles after START → BUSY=0, DONE=0, IRQ_EN=0, HREADYOUT=1. A new START after release completes with correct C.
- Address-edge cases: write/read idx=N*N in A (N=4) → ignored / reads 0. A write to C is ignored. A second START while BUSY does not restart (DONE timing unchanged).
